dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter sharing the single-port synchronous data memory (`MEM`, 1-cycle read latency) between the processor's MM-stage access and a host/loader port. The CPU has priority. A starvation counter bounds how long the host waits, and a lock mode gives the host exclusive access for program/data loading while the processor is held off. Read data is routed back to the requester that issued the read, with a registered owner tag. A saturating stall counter is exported for debug.

## Interface
- `AW`, 32, word address width (matches the dmem `addr` port)
- `DW`, 32, data width
- `MAXWAIT`, 4, maximum consecutive cycles the host can be denied while requesting (1..255)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `cpu_req` in 1: CPU access request, held until granted
- `cpu_we` in 1: 1 = write, 0 = read
- `cpu_addr` in AW: CPU address
- `cpu_wdata` in DW: CPU write data
- `cpu_gnt` out 1: CPU access accepted this cycle (combinational)
- `cpu_rvalid` out 1: CPU read data valid (registered)
- `cpu_rdata` out DW: CPU read data
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_gnt`, `host_rvalid`, `host_rdata`: same meanings, for the host
- `lock_req` in 1: host requests exclusive access
- `lock_ack` out 1: lock mode active
- `mem_addr` out AW, `mem_in` out DW, `mem_we` out 1: to the dmem port
- `mem_out` in DW: dmem read data, valid one cycle after the address
- `stall_cnt` out 32: cycles with `cpu_req && !cpu_gnt`, saturating

## Operation
- States: `NORMAL`, `LOCK`. Reset state is `NORMAL`.
- `NORMAL` → `LOCK` when `lock_req` = 1. `LOCK` → `NORMAL` when `lock_req` = 0. Both transitions are registered, so a change takes effect the cycle after `lock_req` changes. `lock_ack` = (state == `LOCK`).
- Grant in `NORMAL`:
  - `host_gnt` = `host_req && (!cpu_req || wait_cnt == MAXWAIT)`
  - `cpu_gnt` = `cpu_req && !host_gnt`
- Grant in `LOCK`: `host_gnt` = `host_req`; `cpu_gnt` = 0.
- At most one grant per cycle. `mem_addr`, `mem_in` and `mem_we` are muxed combinationally from the granted requester.
- `mem_we` = grant && `we` of the granted requester. With no grant: `mem_we` = 0, `mem_addr` = 0, `mem_in` = 0.
- `wait_cnt` (8 bit):
  - Increments when `host_req && !host_gnt`.
  - Clears when `host_gnt` or `!host_req`.
  - Never exceeds `MAXWAIT`.
- Read return: `owner` register ∈ {none, cpu, host} is loaded each cycle with the granted read requester, or none.
  - `cpu_rvalid` = (owner == cpu); `host_rvalid` = (owner == host).
  - `cpu_rdata` = `host_rdata` = `mem_out`; this is only meaningful while the matching `rvalid` is high.
- `stall_cnt` increments when `cpu_req && !cpu_gnt`, in either state, and saturates at 0xFFFFFFFF.
- Arithmetic: all counters are unsigned. `wait_cnt` compares against `MAXWAIT[7:0]`.

## Timing
- Grant latency: 0 cycles (same cycle as `req`). Read data latency: 1 cycle after grant. Write completes at the granting edge.
- Back-to-back grants are allowed every cycle. Pipelined reads from alternating requesters return in order, each tagged correctly.
- Worst-case host latency in `NORMAL`: `MAXWAIT` denied cycles, then granted on the next cycle.
- Lock entry while the CPU is requesting: the CPU is granted in the entry cycle, and `cpu_gnt` = 0 from the first `LOCK` cycle.
- A read granted in the last `NORMAL` cycle still returns its `rvalid` in the first `LOCK` cycle.
- Reset values, asynchronous on `rst_n` low:
  - state = `NORMAL`, `owner` = none, `wait_cnt` = 0, `stall_cnt` = 0.
  - `cpu_rvalid` = `host_rvalid` = 0, `lock_ack` = 0.
  - While `rst_n` = 0, all grants and `mem_we` are forced to 0.
- Reset mid-read: the pending `rvalid` is dropped and no data is delivered after reset releases.

## Structure
- Shared include `ARB.v`: state encodings `ARB_NORMAL`/`ARB_LOCK` and owner encodings `OWN_NONE`/`OWN_CPU`/`OWN_HOST`.
- No sub-module is needed. The grant mux, the counters and the 2-state FSM live in `dmem_arbiter`.
- The existing `MEM` instance connects directly to the `mem_*` ports.

## Test plan
- CPU read at 0x10 (mem[0x10] = 0xDEADBEEF), host idle → `cpu_gnt` = 1 in the same cycle; next cycle `cpu_rvalid` = 1, `cpu_rdata` = 0xDEADBEEF, `host_rvalid` = 0.
- CPU and host both request continuously, `MAXWAIT` = 4 → host denied 4 cycles and granted on the 5th; CPU `stall_cnt` = 1 after that cycle; the pattern repeats with period 5.
- Host write 0x55 to 0x20 in a cycle where `cpu_req` = 0, then CPU read of 0x20 next cycle → `cpu_rdata` = 0x55.
- Assert `lock_req` with `cpu_req` held high → CPU granted on the entry cycle; `lock_ack` = 1 next cycle with `cpu_gnt` = 0 throughout; host grants every cycle; `stall_cnt` counts each locked cycle.
- Deassert `lock_req` → `lock_ack` = 0 next cycle and the CPU is granted that cycle.
- Host read issued, `rst_n` pulsed low mid-cycle before the return edge → `host_rvalid` stays 0 and all counters read 0 after release.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared encodings for the data-memory arbiter: the two FSM states, the
//   read-return owner tag values, and a saturating increment helper used by
//   the debug stall counter.
package dmem_arbiter_pkg;

  // Arbiter mode. NORMAL: CPU has priority, host protected by a starvation
  // bound. LOCK: host owns the memory exclusively.
  localparam logic [0:0] ARB_NORMAL = 1'b0;
  localparam logic [0:0] ARB_LOCK   = 1'b1;

  // Who issued the read whose data appears on mem_out this cycle.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_HOST = 2'd2;

  // Width of the host starvation counter.
  localparam int unsigned WAIT_W = 8;

  // 32-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port synchronous data memory (1-cycle read latency)
//   between the CPU MM-stage port and a host/loader port.
//   - CPU has priority; a host that keeps requesting is granted after at
//     most MAXWAIT denied cycles.
//   - lock_req switches to LOCK mode (one cycle later), where only the host
//     is served and the CPU is held off.
//   - Read data is returned on both rdata buses; a registered owner tag
//     raises the rvalid of the requester that issued the read.
//   - stall_cnt counts CPU request cycles that were not granted (saturating).
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   cpu_req/we/addr/wdata          CPU request side (req held until granted)
//   cpu_gnt                        CPU accepted this cycle (combinational)
//   cpu_rvalid, cpu_rdata          CPU read return (one cycle after grant)
//   host_*                         same set for the host
//   lock_req, lock_ack             exclusive host mode request / active
//   mem_addr, mem_in, mem_we       to the dmem port
//   mem_out                        dmem read data
//   stall_cnt                      debug: CPU stalled cycles, saturating
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MAXWAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,

  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,

  input  logic          lock_req,
  output logic          lock_ack,

  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_in,
  output logic          mem_we,
  input  logic [DW-1:0] mem_out,

  output logic [31:0]   stall_cnt
);

  localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAXWAIT);

  logic [0:0]        r_state;
  logic [0:0]        w_state_d;
  logic [1:0]        r_owner;
  logic [1:0]        w_owner_d;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_d;
  logic [31:0]       r_stall_cnt;
  logic [31:0]       w_stall_d;

  logic w_cpu_gnt;
  logic w_host_gnt;

  // Grant decision. Gating with rst_n keeps the memory untouched while the
  // arbiter is held in reset, whatever the requesters drive.
  always_comb begin
    w_cpu_gnt  = 1'b0;
    w_host_gnt = 1'b0;
    if (rst_n) begin
      if (r_state == ARB_LOCK) begin
        w_host_gnt = host_req;
      end else begin
        w_host_gnt = host_req && (!cpu_req || (r_wait_cnt == MaxWait));
        w_cpu_gnt  = cpu_req && !w_host_gnt;
      end
    end
  end

  assign cpu_gnt  = w_cpu_gnt;
  assign host_gnt = w_host_gnt;

  // Memory port mux; idle port drives zeros so nothing stray reaches dmem.
  always_comb begin
    mem_addr = '0;
    mem_in   = '0;
    mem_we   = 1'b0;
    if (w_host_gnt) begin
      mem_addr = host_addr;
      mem_in   = host_wdata;
      mem_we   = host_we;
    end else if (w_cpu_gnt) begin
      mem_addr = cpu_addr;
      mem_in   = cpu_wdata;
      mem_we   = cpu_we;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = lock_req ? ARB_LOCK : ARB_NORMAL;

    w_owner_d = OWN_NONE;
    if (w_cpu_gnt && !cpu_we) begin
      w_owner_d = OWN_CPU;
    end else if (w_host_gnt && !host_we) begin
      w_owner_d = OWN_HOST;
    end

    // Consecutive host denials; clamped so it can never pass MaxWait.
    w_wait_d = '0;
    if (host_req && !w_host_gnt) begin
      w_wait_d = (r_wait_cnt >= MaxWait) ? MaxWait : r_wait_cnt + WAIT_W'(1);
    end

    w_stall_d = r_stall_cnt;
    if (cpu_req && !w_cpu_gnt) begin
      w_stall_d = sat_inc32(r_stall_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB_NORMAL;
      r_owner     <= OWN_NONE;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_owner     <= w_owner_d;
      r_wait_cnt  <= w_wait_d;
      r_stall_cnt <= w_stall_d;
    end
  end

  assign lock_ack    = (r_state == ARB_LOCK);
  assign cpu_rvalid  = (r_owner == OWN_CPU);
  assign host_rvalid = (r_owner == OWN_HOST);
  // Both requesters see the raw memory output; rvalid says whose it is.
  assign cpu_rdata   = mem_out;
  assign host_rdata  = mem_out;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned MAXWAIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          lock_req, lock_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_in, mem_out;
  logic          mem_we;
  logic [31:0]   stall_cnt;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(MAXWAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .lock_req(lock_req), .lock_ack(lock_ack),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_we(mem_we), .mem_out(mem_out),
    .stall_cnt(stall_cnt)
  );

  // Synchronous single-port memory, 1-cycle read latency, 256 words.
  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  logic          mem_init;
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_in;
    end
    mem_out <= mem[mem_addr[7:0]];
  end

  // Reference model state.
  bit          m_lock;
  int unsigned m_wait;
  logic [31:0] m_stall;
  int          m_owner;   // 0 none, 1 cpu, 2 host
  logic [31:0] m_rdata;
  logic [31:0] shadow [256];
  // Expected combinational outputs for the cycle being driven.
  bit          e_cgnt, e_hgnt, e_mwe;
  logic [31:0] e_maddr, e_min;

  int n_total, n_bad;

  task automatic model_reset();
    m_lock = 1'b0; m_wait = 0; m_stall = '0; m_owner = 0; m_rdata = '0;
    e_cgnt = 1'b0; e_hgnt = 1'b0; e_mwe = 1'b0; e_maddr = '0; e_min = '0;
  endtask

  // Drive one cycle of requests at the falling edge and predict the grants.
  task automatic apply(input bit creq, input bit cwe, input logic [31:0] caddr,
                       input logic [31:0] cwd, input bit hreq, input bit hwe,
                       input logic [31:0] haddr, input logic [31:0] hwd, input bit lreq);
    @(negedge clk);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
    lock_req = lreq;
    #1;
    if (m_lock) begin
      e_hgnt = hreq;
      e_cgnt = 1'b0;
    end else begin
      e_hgnt = hreq && (!creq || m_wait == MAXWAIT);
      e_cgnt = creq && !e_hgnt;
    end
    e_mwe = 1'b0; e_maddr = '0; e_min = '0;
    if (e_hgnt) begin
      e_mwe = hwe; e_maddr = haddr; e_min = hwd;
    end else if (e_cgnt) begin
      e_mwe = cwe; e_maddr = caddr; e_min = cwd;
    end
  endtask

  // Advance through the rising edge and update the model.
  task automatic tick();
    @(posedge clk);
    m_owner = 0;
    if (e_cgnt) begin
      if (cpu_we) shadow[cpu_addr[7:0]] = cpu_wdata;
      else begin m_owner = 1; m_rdata = shadow[cpu_addr[7:0]]; end
    end else if (e_hgnt) begin
      if (host_we) shadow[host_addr[7:0]] = host_wdata;
      else begin m_owner = 2; m_rdata = shadow[host_addr[7:0]]; end
    end
    if (host_req && !e_hgnt) m_wait = (m_wait + 1 > MAXWAIT) ? MAXWAIT : m_wait + 1;
    else m_wait = 0;
    if (cpu_req && !e_cgnt && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    m_lock = lock_req;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    cpu_req = 1'b1; host_req = 1'b1; host_we = 1'b1; cpu_we = 1'b1;
    #1;
    n_total++;
    if (cpu_gnt !== 1'b0 || host_gnt !== 1'b0 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_grants: got cpu_gnt=%b host_gnt=%b mem_we=%b want 0/0/0",
               cpu_gnt, host_gnt, mem_we);
    end
    n_total++;
    if (cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0 || lock_ack !== 1'b0 ||
        stall_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_regs: got crv=%b hrv=%b lock=%b stall=%0d want 0/0/0/0",
               cpu_rvalid, host_rvalid, lock_ack, stall_cnt);
    end
    @(negedge clk);
    cpu_req = 1'b0; host_req = 1'b0; cpu_we = 1'b0; host_we = 1'b0;
    rst_n = 1'b1;
    model_reset();
    tick();
    n_total++;
    if (stall_cnt !== 32'd0 || lock_ack !== 1'b0 || cpu_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got stall=%0d lock=%b crv=%b want 0/0/0",
               stall_cnt, lock_ack, cpu_rvalid);
    end
  endtask

  task automatic test_cpu_read();
    apply(0, 0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF, 0);
    n_total++;
    if (host_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_in !== 32'hDEADBEEF)
    begin
      n_bad++;
      $display("FAIL preload_write: got gnt=%b we=%b addr=%h in=%h want 1/1/10/deadbeef",
               host_gnt, mem_we, mem_addr, mem_in);
    end
    tick();
    apply(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    n_total++;
    if (cpu_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin
      n_bad++;
      $display("FAIL cpu_read_gnt: got gnt=%b we=%b addr=%h want 1/0/10",
               cpu_gnt, mem_we, mem_addr);
    end
    tick();
    cpu_req = 1'b0;
    n_total++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || host_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL cpu_read_data: got rv=%b data=%h hrv=%b want 1/deadbeef/0",
               cpu_rvalid, cpu_rdata, host_rvalid);
    end
  endtask

  task automatic test_host_write_then_cpu_read();
    apply(0, 0, 0, 0, 1, 1, 32'h20, 32'h55, 0);
    n_total++;
    if (host_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL hw_gnt: got host=%b cpu=%b want 1/0", host_gnt, cpu_gnt);
    end
    tick();
    apply(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    tick();
    n_total++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h55) begin
      n_bad++;
      $display("FAIL hw_cpu_read: got rv=%b data=%h want 1/55", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_starvation();
    logic [31:0] s0;
    s0 = stall_cnt;
    for (int i = 0; i < 15; i++) begin
      apply(1, 0, 32'(8'h40 + i), 0, 1, 0, 32'(8'h80 + i), 0, 0);
      n_total++;
      if (host_gnt !== ((i % 5) == 4) || cpu_gnt !== ((i % 5) != 4) ||
          host_gnt !== e_hgnt || mem_addr !== e_maddr) begin
        n_bad++;
        $display("FAIL starve_gnt[%0d]: got host=%b cpu=%b addr=%h want host=%b cpu=%b addr=%h",
                 i, host_gnt, cpu_gnt, mem_addr, e_hgnt, e_cgnt, e_maddr);
      end
      tick();
      n_total++;
      if (host_rvalid !== (m_owner == 2) || cpu_rvalid !== (m_owner == 1) ||
          cpu_rdata !== m_rdata) begin
        n_bad++;
        $display("FAIL starve_ret[%0d]: got hrv=%b crv=%b data=%h want owner=%0d data=%h",
                 i, host_rvalid, cpu_rvalid, cpu_rdata, m_owner, m_rdata);
      end
      if (i == 4) begin
        n_total++;
        if (stall_cnt !== s0 + 32'd1) begin
          n_bad++;
          $display("FAIL starve_stall: got %0d want %0d", stall_cnt, s0 + 32'd1);
        end
      end
    end
    cpu_req = 1'b0; host_req = 1'b0;
  endtask

  task automatic test_lock();
    logic [31:0] s0;
    s0 = m_stall;
    apply(1, 0, 32'h30, 0, 0, 0, 0, 0, 1);
    n_total++;
    if (cpu_gnt !== 1'b1 || lock_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_entry_gnt: got cpu_gnt=%b lock=%b want 1/0", cpu_gnt, lock_ack);
    end
    tick();
    n_total++;
    if (lock_ack !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== m_rdata) begin
      n_bad++;
      $display("FAIL lock_entry_ret: got lock=%b crv=%b data=%h want 1/1/%h",
               lock_ack, cpu_rvalid, cpu_rdata, m_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 32'h30, 0, 1, 0, 32'($urandom_range(255)), 0, 1);
      n_total++;
      if (cpu_gnt !== 1'b0 || host_gnt !== 1'b1) begin
        n_bad++;
        $display("FAIL lock_gnt[%0d]: got cpu=%b host=%b want 0/1", i, cpu_gnt, host_gnt);
      end
      tick();
      n_total++;
      if (host_rvalid !== 1'b1 || host_rdata !== m_rdata || stall_cnt !== m_stall) begin
        n_bad++;
        $display("FAIL lock_ret[%0d]: got hrv=%b data=%h stall=%0d want 1/%h/%0d",
                 i, host_rvalid, host_rdata, stall_cnt, m_rdata, m_stall);
      end
    end
    apply(1, 0, 32'h30, 0, 1, 0, 32'h31, 0, 0);
    n_total++;
    if (cpu_gnt !== 1'b0 || host_gnt !== 1'b1 || lock_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL unlock_req_cycle: got cpu=%b host=%b lock=%b want 0/1/1",
               cpu_gnt, host_gnt, lock_ack);
    end
    tick();
    n_total++;
    if (lock_ack !== 1'b0 || stall_cnt !== s0 + 32'd5) begin
      n_bad++;
      $display("FAIL unlock_ack: got lock=%b stall=%0d want 0/%0d", lock_ack, stall_cnt,
               s0 + 32'd5);
    end
    apply(1, 0, 32'h30, 0, 1, 0, 32'h31, 0, 0);
    n_total++;
    if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL unlock_cpu_gnt: got cpu=%b host=%b want 1/0", cpu_gnt, host_gnt);
    end
    tick();
    cpu_req = 1'b0; host_req = 1'b0;
  endtask

  task automatic test_random();
    bit lreq;
    lreq = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19) == 0) lreq = !lreq;
      apply($urandom_range(9) < 7, $urandom_range(1) == 1, 32'($urandom_range(255)),
            $urandom, $urandom_range(1) == 1, $urandom_range(1) == 1,
            32'($urandom_range(255)), $urandom, lreq);
      n_total++;
      if (cpu_gnt !== e_cgnt || host_gnt !== e_hgnt || mem_we !== e_mwe ||
          mem_addr !== e_maddr || mem_in !== e_min) begin
        n_bad++;
        $display("FAIL rand_comb[%0d]: got c=%b h=%b we=%b a=%h d=%h want c=%b h=%b we=%b a=%h d=%h",
                 i, cpu_gnt, host_gnt, mem_we, mem_addr, mem_in,
                 e_cgnt, e_hgnt, e_mwe, e_maddr, e_min);
      end
      tick();
      n_total++;
      if (cpu_rvalid !== (m_owner == 1) || host_rvalid !== (m_owner == 2) ||
          lock_ack !== m_lock || stall_cnt !== m_stall ||
          (m_owner != 0 && cpu_rdata !== m_rdata)) begin
        n_bad++;
        $display("FAIL rand_reg[%0d]: got crv=%b hrv=%b lock=%b stall=%0d data=%h want owner=%0d lock=%b stall=%0d data=%h",
                 i, cpu_rvalid, host_rvalid, lock_ack, stall_cnt, cpu_rdata,
                 m_owner, m_lock, m_stall, m_rdata);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    apply(0, 0, 0, 0, 1, 0, 32'h40, 0, 0);
    n_total++;
    if (host_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_issue: got host_gnt=%b want 1", host_gnt);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (host_gnt !== 1'b0 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_gnt: got host_gnt=%b mem_we=%b want 0/0", host_gnt, mem_we);
    end
    @(posedge clk); #1;
    n_total++;
    if (host_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_rvalid_in_reset: got %b want 0", host_rvalid);
    end
    @(negedge clk);
    cpu_req = 1'b0; host_req = 1'b0; lock_req = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    n_total++;
    if (host_rvalid !== 1'b0 || cpu_rvalid !== 1'b0 || stall_cnt !== 32'd0 ||
        lock_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_release: got hrv=%b crv=%b stall=%0d lock=%b want 0/0/0/0",
               host_rvalid, cpu_rvalid, stall_cnt, lock_ack);
    end
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    rst_n = 1'b0; mem_init = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    lock_req = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    test_reset();
    test_cpu_read();
    test_host_write_then_cpu_read();
    test_starvation();
    test_lock();
    test_random();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
